// File: rtl/scale_shift_pkg.sv
// ============================================================================
// scale_shift_pkg : shared constants and shift/round helpers for scale_shift
// Revision 1.0
// ============================================================================
`default_nettype none

package scale_shift_pkg;

  localparam int PIPE_LATENCY = 2;

  // Stored shift values above the width headroom are pinned to it.
  function automatic int unsigned clamp_shift(input int unsigned s,
                                              input int unsigned smax);
    return (s > smax) ? smax : s;
  endfunction

  function automatic bit rnd_active(input bit use_rnd, input int unsigned s);
    return use_rnd && (s != 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/scale_shift_sat_round.sv
// ============================================================================
// sat_round : combinational shift / round-half-up / saturate of one sample
// Revision 1.0
// ============================================================================
`default_nettype none

module sat_round
  import scale_shift_pkg::*;
#(
  parameter int DW      = 32,
  parameter int OW      = 20,
  parameter int SW      = 4,
  parameter bit USE_SAT = 1'b1,
  parameter bit USE_RND = 1'b1
) (
  input  logic signed [DW-1:0] i_data,
  input  logic        [SW-1:0] i_shift,
  output logic        [OW-1:0] o_data,
  output logic                 o_ovf
);

  localparam int unsigned       C_MAXS = DW - OW;
  localparam logic signed [DW:0] C_ONE = (DW+1)'(1);
  localparam logic signed [DW:0] C_HI  = {{(DW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [DW:0] C_LO  = {{(DW-OW+2){1'b1}}, {(OW-1){1'b0}}};

  int unsigned         w_s;
  logic signed [DW:0]  w_bias;
  logic signed [DW:0]  w_sum;
  logic signed [DW:0]  w_r;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    w_s    = clamp_shift(32'(i_shift), C_MAXS);
    w_bias = rnd_active(USE_RND, w_s) ? (C_ONE <<< (w_s - 1)) : '0;
    w_sum  = {i_data[DW-1], i_data} + w_bias;
    w_r    = w_sum >>> w_s;
    o_ovf  = (w_r > C_HI) || (w_r < C_LO);
    if (o_ovf && USE_SAT) begin
      o_data = w_r[DW] ? C_LO[OW-1:0] : C_HI[OW-1:0];
    end else begin
      o_data = w_r[OW-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/scale_shift.sv
// ============================================================================
// scale_shift : per-channel TDM shift/round/saturate, two-cycle pipeline
// Revision 1.0
// ============================================================================
`default_nettype none

module scale_shift
  import scale_shift_pkg::*;
#(
  parameter int DW      = 32,
  parameter int OW      = 20,
  parameter int NCH     = 4,
  parameter int SW      = 4,
  parameter bit USE_SAT = 1'b1,
  parameter bit USE_RND = 1'b1,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          strobe_in,
  input  logic          frame_in,
  input  logic          shift_we,
  input  logic [CW-1:0] shift_addr,
  input  logic [SW-1:0] shift_wdata,
  input  logic          ovf_clr,
  output logic [OW-1:0] data_out,
  output logic          strobe_out,
  output logic [CW-1:0] chan_out,
  output logic          ovf,
  output logic [NCH-1:0] ovf_sticky
);

  if (PIPE_LATENCY != 2 || OW >= DW || NCH < 1 || NCH > 16) begin : g_param_check
    $error("scale_shift: unsupported parameter set");
  end

  localparam logic [CW-1:0] C_LAST = CW'(NCH - 1);

  logic [SW-1:0]  r_shift [NCH];
  logic [CW-1:0]  r_chan;
  logic [CW-1:0]  w_chan;

  logic           r_s1_vld;
  logic [DW-1:0]  r_s1_data;
  logic [CW-1:0]  r_s1_chan;
  logic [SW-1:0]  r_s1_shift;

  logic [OW-1:0]  w_data;
  logic           w_ovf;
  logic [NCH-1:0] w_set;

  logic [OW-1:0]  r_data;
  logic           r_strobe;
  logic [CW-1:0]  r_chan_out;
  logic           r_ovf;
  logic [NCH-1:0] r_sticky;

  always_comb begin
    w_chan = (frame_in || r_chan == C_LAST) ? '0 : r_chan + CW'(1);
    w_set  = (r_s1_vld && w_ovf) ? (NCH'(1) << r_s1_chan) : '0;
  end

  // Stage 1 reads the shift table before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chan     <= C_LAST;
      r_s1_vld   <= 1'b0;
      r_s1_data  <= '0;
      r_s1_chan  <= '0;
      r_s1_shift <= '0;
      for (int i = 0; i < NCH; i++) r_shift[i] <= '0;
    end else begin
      r_s1_vld <= strobe_in;
      if (strobe_in) begin
        r_chan     <= w_chan;
        r_s1_data  <= data_in;
        r_s1_chan  <= w_chan;
        r_s1_shift <= r_shift[w_chan];
      end
      if (shift_we && (32'(shift_addr) < NCH)) begin
        r_shift[shift_addr] <= shift_wdata;
      end
    end
  end

  sat_round #(
    .DW      (DW),
    .OW      (OW),
    .SW      (SW),
    .USE_SAT (USE_SAT),
    .USE_RND (USE_RND)
  ) u_sat_round (
    .i_data  (r_s1_data),
    .i_shift (r_s1_shift),
    .o_data  (w_data),
    .o_ovf   (w_ovf)
  );

  // Outputs hold between strobes; a coincident set beats ovf_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_strobe   <= 1'b0;
      r_data     <= '0;
      r_chan_out <= '0;
      r_ovf      <= 1'b0;
      r_sticky   <= '0;
    end else begin
      r_strobe <= r_s1_vld;
      if (r_s1_vld) begin
        r_data     <= w_data;
        r_chan_out <= r_s1_chan;
        r_ovf      <= w_ovf;
      end
      r_sticky <= (ovf_clr ? '0 : r_sticky) | w_set;
    end
  end

  assign data_out   = r_data;
  assign strobe_out = r_strobe;
  assign chan_out   = r_chan_out;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_scale_shift.sv
// ============================================================================
// tb_scale_shift : randomized bench against an arithmetic reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_scale_shift;

  localparam int DW  = 32;
  localparam int OW  = 20;
  localparam int NCH = 4;
  localparam int SW  = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          strobe_in = 1'b0;
  logic          frame_in = 1'b0;
  logic          shift_we = 1'b0;
  logic [CW-1:0] shift_addr = '0;
  logic [SW-1:0] shift_wdata = '0;
  logic          ovf_clr = 1'b0;
  logic [OW-1:0] data_out;
  logic          strobe_out;
  logic [CW-1:0] chan_out;
  logic          ovf;
  logic [NCH-1:0] ovf_sticky;

  scale_shift #(
    .DW(DW), .OW(OW), .NCH(NCH), .SW(SW), .USE_SAT(1'b1), .USE_RND(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .strobe_in(strobe_in),
    .frame_in(frame_in), .shift_we(shift_we), .shift_addr(shift_addr),
    .shift_wdata(shift_wdata), .ovf_clr(ovf_clr), .data_out(data_out),
    .strobe_out(strobe_out), .chan_out(chan_out), .ovf(ovf),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int     due;
    longint dbits;
    int     chan;
    bit     ov;
  } exp_t;

  exp_t   q[$];
  int     cyc = 0;
  int     m_chan = NCH - 1;
  int     m_shift[NCH];
  int     m_sticky = 0;
  longint e_data = 0;
  int     e_chan = 0;
  bit     e_ovf = 0;

  // Rules applied directly: clamp, round half up, floor shift, saturate.
  function automatic void model_calc(input longint d, input int sh,
                                     output longint dbits, output bit ov);
    longint r;
    longint o;
    int s;
    s  = (sh > DW - OW) ? DW - OW : sh;
    r  = (d + ((s > 0) ? (longint'(1) <<< (s - 1)) : 0)) >>> s;
    ov = (r > 524287) || (r < -524288);
    o  = ov ? ((r > 0) ? 524287 : -524288) : r;
    dbits = o & 64'hFFFFF;
  endfunction

  task automatic cycle(input bit r, input bit st, input bit fr, input logic [31:0] d,
                       input bit we, input int wa, input int wd, input bit clr);
    exp_t e;
    int   set;
    rst = r; strobe_in = st; frame_in = fr; data_in = d;
    shift_we = we; shift_addr = CW'(wa); shift_wdata = SW'(wd); ovf_clr = clr;
    if (r) begin
      q.delete();
      m_chan = NCH - 1;
      for (int i = 0; i < NCH; i++) m_shift[i] = 0;
    end else begin
      if (st) begin
        m_chan = fr ? 0 : (m_chan + 1) % NCH;
        e.due  = cyc + 2;
        e.chan = m_chan;
        model_calc(longint'($signed(d)), m_shift[m_chan], e.dbits, e.ov);
        q.push_back(e);
      end
      if (we) m_shift[wa] = wd;
    end
    @(posedge clk);
    #1;
    cyc++;
    set = 0;
    if (r) begin
      m_sticky = 0; e_data = 0; e_chan = 0; e_ovf = 0;
      check("strobe_out", 64'(strobe_out), 64'd0);
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        e_data = e.dbits; e_chan = e.chan; e_ovf = e.ov;
        if (e.ov) set = 1 << e.chan;
        check("strobe_out", 64'(strobe_out), 64'd1);
      end else begin
        check("strobe_out", 64'(strobe_out), 64'd0);
      end
      m_sticky = (clr ? 0 : m_sticky) | set;
    end
    check("data_out", 64'(data_out), 64'(e_data));
    check("chan_out", 64'(chan_out), 64'(e_chan));
    check("ovf", 64'(ovf), 64'(e_ovf));
    check("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 32'd0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) m_shift[i] = 0;
    cycle(1, 0, 0, 32'd0, 0, 0, 0, 0);
    cycle(1, 0, 0, 32'd0, 0, 0, 0, 0);

    // Largest positive value passes unchanged.
    cycle(0, 1, 1, 32'h0007FFFF, 0, 0, 0, 0);
    idle();
    check("max_pos", 64'(data_out), 64'h7FFFF);
    check("max_pos_ovf", 64'(ovf), 64'd0);

    // One past the top saturates and latches, then clears.
    cycle(0, 1, 1, 32'h00080000, 0, 0, 0, 0);
    idle();
    check("sat_pos", 64'(data_out), 64'h7FFFF);
    check("sat_sticky", 64'(ovf_sticky), 64'd1);
    cycle(0, 0, 0, 32'd0, 0, 0, 0, 1);
    check("sticky_clr", 64'(ovf_sticky), 64'd0);

    // Rounding at shift 4 and shift clamp 15 -> 12.
    cycle(0, 0, 0, 32'd0, 1, 0, 4, 0);
    cycle(0, 1, 1, -32'sd8, 0, 0, 0, 0);
    idle();
    check("rnd_m8", 64'(data_out), 64'h0);
    cycle(0, 1, 1, -32'sd9, 0, 0, 0, 0);
    idle();
    check("rnd_m9", 64'(data_out), 64'hFFFFF);
    cycle(0, 0, 0, 32'd0, 1, 0, 15, 0);
    cycle(0, 1, 1, 32'h00001000, 0, 0, 0, 0);
    idle();
    check("clamp15", 64'(data_out), 64'h1);
    cycle(0, 0, 0, 32'd0, 1, 0, 0, 0);

    // Channel sequence across a wrap.
    for (int i = 0; i < 5; i++) cycle(0, 1, (i == 0), 32'(i * 7), 0, 0, 0, 0);
    idle(); idle();

    // Same-cycle shift write uses the old value for that sample.
    cycle(0, 1, 1, 32'h0, 0, 0, 0, 0);
    cycle(0, 1, 0, 32'h0, 0, 0, 0, 0);
    cycle(0, 1, 0, 32'h100, 1, 2, 3, 0);
    idle();
    check("wr_old", 64'(data_out), 64'h100);
    cycle(0, 1, 0, 32'h0, 0, 0, 0, 0);
    cycle(0, 1, 1, 32'h0, 0, 0, 0, 0);
    cycle(0, 1, 0, 32'h0, 0, 0, 0, 0);
    cycle(0, 1, 0, 32'h100, 0, 0, 0, 0);
    idle();
    check("wr_new", 64'(data_out), 64'h20);

    // Reset right after a strobe flushes it.
    cycle(0, 1, 1, 32'h1234, 0, 0, 0, 0);
    cycle(1, 0, 0, 32'd0, 0, 0, 0, 0);
    idle(); idle();

    for (int n = 0; n < 600; n++) begin
      bit          r, st, fr, we, clr;
      int          wa, wd, sh;
      logic [31:0] d;
      r   = ($urandom_range(0, 79) == 0);
      st  = ($urandom_range(0, 3) != 0);
      fr  = ($urandom_range(0, 6) == 0);
      we  = !r && ($urandom_range(0, 4) == 0);
      clr = ($urandom_range(0, 15) == 0);
      wa  = $urandom_range(0, NCH - 1);
      wd  = $urandom_range(0, 15);
      sh  = $urandom_range(0, 12);
      case ($urandom_range(0, 2))
        0: d = $urandom;
        1: d = 32'($urandom_range(0, 4095)) - 32'd2048 + (32'h00080000 << sh);
        default: d = 32'($urandom_range(0, 4095)) - 32'd2048 - (32'h00080000 << sh);
      endcase
      cycle(r, st, fr, d, we, wa, wd, clr);
    end
    idle(); idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
